out_sel_decode: RTL and testbench

- Inverse of the router's allocation-to-index translation. Takes one output-port index per input port and decodes it back to per-input one-hot allocation vectors and per-output crossbar column selects.
- Registered, one-stage valid/ready pipeline between port allocation and the crossbar, with conflict/illegal-code detection and a saturating error counter for debug.

---
 rtl/out_sel_decode.sv | 106 ++++++++++
 tb/tb_out_sel_decode.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/out_sel_decode.sv
// out_sel_decode
// Turns one output-port index per input port back into per-input one-hot
// allocation vectors and per-output crossbar column selects. The decoded word
// passes through a single registered valid/ready stage. Words that contain a
// port conflict or an illegal code are flagged, and a saturating debug counter
// keeps track of how many such words were accepted.
module out_sel_decode #(
  parameter int NUM_PORT     = 5,
  parameter int LOG_NUM_PORT = 3,
  parameter int CNT_W        = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_PORT*LOG_NUM_PORT-1:0] out_sel,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_PORT*NUM_PORT-1:0]     alloc,
  output logic [NUM_PORT*LOG_NUM_PORT-1:0] xbar_sel,
  output logic [NUM_PORT-1:0]              port_busy,
  output logic                             conflict,
  output logic                             illegal,
  input  logic                             err_clr,
  output logic [CNT_W-1:0]                 err_cnt
);

  // The all-ones index means "no port requested"
  localparam logic [LOG_NUM_PORT-1:0] IDLE_CODE = '1;
  localparam logic [LOG_NUM_PORT-1:0] NUM_CODE  = LOG_NUM_PORT'(NUM_PORT);

  logic [NUM_PORT*NUM_PORT-1:0]     alloc_d;
  logic [NUM_PORT*LOG_NUM_PORT-1:0] xbar_d;
  logic [NUM_PORT-1:0]              busy_d;
  logic                             conflict_d;
  logic                             illegal_d;
  logic                             accept;

  // The stage can take a new word when it is empty or its word leaves this cycle
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Decode the incoming indices: one-hot per input and lowest-index winner per output
  always_comb begin
    logic [LOG_NUM_PORT-1:0] code;
    alloc_d    = '0;
    xbar_d     = '1;
    busy_d     = '0;
    conflict_d = 1'b0;
    illegal_d  = 1'b0;
    code       = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      code = out_sel[i*LOG_NUM_PORT +: LOG_NUM_PORT];
      if (code < NUM_CODE) begin
        alloc_d[i*NUM_PORT +: NUM_PORT] = NUM_PORT'(1) << code;
      end else if (code != IDLE_CODE) begin
        illegal_d = 1'b1;
      end
    end
    for (int j = 0; j < NUM_PORT; j++) begin
      for (int i = 0; i < NUM_PORT; i++) begin
        if (out_sel[i*LOG_NUM_PORT +: LOG_NUM_PORT] == LOG_NUM_PORT'(j)) begin
          if (busy_d[j]) begin
            conflict_d = 1'b1;
          end else begin
            busy_d[j]                              = 1'b1;
            xbar_d[j*LOG_NUM_PORT +: LOG_NUM_PORT] = LOG_NUM_PORT'(i);
          end
        end
      end
    end
  end

  // Output register: load on accept, drop valid once consumed, keep data otherwise
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      alloc     <= '0;
      xbar_sel  <= '1;
      port_busy <= '0;
      conflict  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alloc     <= alloc_d;
      xbar_sel  <= xbar_d;
      port_busy <= busy_d;
      conflict  <= conflict_d;
      illegal   <= illegal_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Debug counter of accepted faulty words; clear beats increment, never wraps
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (accept && (conflict_d || illegal_d) && (err_cnt != '1)) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_out_sel_decode.sv
// tb_out_sel_decode
// Drives directed and random words into out_sel_decode. A reference model
// pushes the expected decoded word into a scoreboard queue whenever a word is
// accepted; an independent monitor consumes queue entries as the DUT hands
// words downstream and checks the handshake and error counter every cycle.
module tb_out_sel_decode;

  localparam int NP = 5;
  localparam int LP = 3;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [NP*LP-1:0]  out_sel;
  logic              out_valid;
  logic              out_ready;
  logic [NP*NP-1:0]  alloc;
  logic [NP*LP-1:0]  xbar_sel;
  logic [NP-1:0]     port_busy;
  logic              conflict;
  logic              illegal;
  logic              err_clr;
  logic [CW-1:0]     err_cnt;

  typedef struct packed {
    logic [NP*NP-1:0] alloc;
    logic [NP*LP-1:0] xbar;
    logic [NP-1:0]    busy;
    logic             conf;
    logic             ill;
  } word_t;

  localparam word_t RESET_WORD = '{alloc: '0, xbar: '1, busy: '0, conf: 1'b0, ill: 1'b0};

  word_t sb[$];
  bit    model_valid = 1'b0;
  int    model_cnt   = 0;
  int    rst_gen     = 0;
  int    flush_idx   = 0;
  int    total       = 0;
  int    bad         = 0;

  out_sel_decode #(.NUM_PORT(NP), .LOG_NUM_PORT(LP), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alloc     (alloc),
    .xbar_sel  (xbar_sel),
    .port_busy (port_busy),
    .conflict  (conflict),
    .illegal   (illegal),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Expected decode built by counting claims per output port
  function automatic word_t refDecode(input logic [NP*LP-1:0] sel);
    word_t w;
    int    claims[NP];
    int    code;
    w = RESET_WORD;
    for (int j = 0; j < NP; j++) claims[j] = 0;
    for (int i = 0; i < NP; i++) begin
      code = int'(sel[i*LP +: LP]);
      if (code < NP) begin
        w.alloc[i*NP + code] = 1'b1;
        if (claims[code] == 0) w.xbar[code*LP +: LP] = LP'(i);
        claims[code] = claims[code] + 1;
      end else if (code != (1 << LP) - 1) begin
        w.ill = 1'b1;
      end
    end
    for (int j = 0; j < NP; j++) begin
      w.busy[j] = (claims[j] > 0);
      if (claims[j] > 1) w.conf = 1'b1;
    end
    return w;
  endfunction

  function automatic logic [NP*LP-1:0] mk(input int c4, input int c3, input int c2,
                                          input int c1, input int c0);
    return {LP'(c4), LP'(c3), LP'(c2), LP'(c1), LP'(c0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic vld, input logic [NP*LP-1:0] sel,
                               input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    reset     = rst;
    in_valid  = vld;
    out_sel   = sel;
    out_ready = rdy;
    err_clr   = clr;
  endtask

  // Reference model: decides acceptance, pushes expected words, tracks the counter
  always @(posedge clk) begin
    word_t w;
    bit    acc;
    if (!reset) begin
      model_valid = 1'b0;
      model_cnt   = 0;
      flush_idx   = sb.size();
      rst_gen     = rst_gen + 1;
    end else begin
      acc = in_valid && (!model_valid || out_ready);
      w   = refDecode(out_sel);
      if (err_clr) model_cnt = 0;
      else if (acc && (w.conf || w.ill) && model_cnt < CNT_MAX) model_cnt = model_cnt + 1;
      if (acc) begin
        sb.push_back(w);
        model_valid = 1'b1;
      end else if (out_ready) begin
        model_valid = 1'b0;
      end
    end
  end

  // Monitor: compares the presented word with the scoreboard head, consumes it on handshake
  initial begin
    int    rd;
    int    seen_gen;
    word_t last_w;
    word_t exp_w;
    rd       = 0;
    seen_gen = 0;
    last_w   = RESET_WORD;
    forever begin
      @(negedge clk);
      if (rst_gen != seen_gen) begin
        seen_gen = rst_gen;
        rd       = flush_idx;
        last_w   = RESET_WORD;
      end
      if (rst_gen > 0) begin
        checkOutput("out_valid", 32'(out_valid), 32'(model_valid));
        checkOutput("in_ready", 32'(in_ready), 32'(!model_valid || out_ready));
        checkOutput("err_cnt", 32'(err_cnt), 32'(model_cnt));
        if (model_valid) begin
          if (rd >= sb.size()) begin
            checkOutput("scoreboard_empty", 32'(sb.size()), 32'(rd + 1));
            exp_w = last_w;
          end else begin
            exp_w = sb[rd];
          end
        end else begin
          exp_w = last_w;
        end
        checkOutput("alloc", 32'(alloc), 32'(exp_w.alloc));
        checkOutput("xbar_sel", 32'(xbar_sel), 32'(exp_w.xbar));
        checkOutput("port_busy", 32'(port_busy), 32'(exp_w.busy));
        if (model_valid) begin
          checkOutput("conflict", 32'(conflict), 32'(exp_w.conf));
          checkOutput("illegal", 32'(illegal), 32'(exp_w.ill));
          if (out_ready && rd < sb.size()) begin
            last_w = exp_w;
            rd     = rd + 1;
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios, random traffic, saturation, clear and mid-stall reset
  initial begin
    logic [NP*LP-1:0] idle_sel;
    logic [NP*LP-1:0] conf_sel;
    logic [NP*LP-1:0] rsel;
    idle_sel  = '1;
    conf_sel  = mk(7, 2, 7, 2, 7);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_sel   = idle_sel;
    out_ready = 1'b1;
    err_clr   = 1'b0;

    applyStimulus(0, 0, idle_sel, 1, 0);
    applyStimulus(0, 0, idle_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);

    applyStimulus(1, 1, mk(0, 1, 2, 3, 4), 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 1, conf_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 1, mk(7, 7, 7, 7, 5), 1, 0);
    applyStimulus(1, 1, mk(6, 7, 0, 7, 7), 1, 0);
    applyStimulus(1, 1, idle_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);

    applyStimulus(1, 1, mk(4, 3, 2, 1, 0), 1, 0);
    applyStimulus(1, 1, mk(1, 1, 7, 0, 3), 0, 0);
    applyStimulus(1, 1, mk(1, 1, 7, 0, 3), 0, 0);
    applyStimulus(1, 1, mk(1, 1, 7, 0, 3), 0, 0);
    applyStimulus(1, 1, mk(1, 1, 7, 0, 3), 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NP; i++) begin
        rsel[i*LP +: LP] = LP'($urandom_range(0, 7));
      end
      applyStimulus(1, 1'($urandom_range(0, 3) != 0), rsel,
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
    end
    applyStimulus(1, 0, idle_sel, 1, 1);

    for (int n = 0; n < 260; n++) applyStimulus(1, 1, conf_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 1, conf_sel, 1, 1);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 1, mk(7, 7, 7, 7, 6), 1, 0);
    applyStimulus(1, 1, mk(0, 0, 0, 0, 0), 1, 0);

    applyStimulus(1, 1, mk(3, 7, 4, 7, 1), 0, 0);
    applyStimulus(1, 1, mk(2, 2, 7, 7, 7), 0, 0);
    applyStimulus(0, 1, mk(2, 2, 7, 7, 7), 0, 0);
    applyStimulus(1, 0, idle_sel, 0, 0);
    applyStimulus(1, 1, mk(0, 1, 2, 3, 4), 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);
    applyStimulus(1, 0, idle_sel, 1, 0);

    @(negedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
